dec_scan_ctrl: RTL and testbench

Sequential address/enable generator that sits directly upstream of the enabled decoder and drives its E and address inputs. It steps through addresses 0..N-1, holding each for DWELL cycles, with GAP blanking cycles (enable low) between addresses. It supports single-shot and looping scans with a start/busy/done handshake. A parameterised enabled decoder instance also provides the one-hot select lines directly.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_n_en.sv | 13 +
 rtl/dec_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_dec_scan_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared state type and helpers for the decoder scan controller.
package dec_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} scan_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned a);
    return MAX_N'(1) << a;
  endfunction

endpackage

// File: rtl/dec_n_en.sv
// N-output decoder with enable: only the addressed output follows en.
module dec_n_en import dec_pkg::*; #(
  parameter int N  = 2,
  parameter int AW = clog2_min1(N)
) (
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  y
);

  always_comb y = en ? N'(onehot(32'(addr))) : '0;

endmodule

// File: rtl/dec_scan_ctrl.sv
// Address/enable sequencer driving an enabled decoder: dwell per address, blank between.
// Optional SCAN_MASK_EN adds a mask input that skips masked addresses.
module dec_scan_ctrl import dec_pkg::*; #(
  parameter int  N     = 2,
  parameter int  DWELL = 4,
  parameter int  GAP   = 1,
  localparam int AW    = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
`ifdef SCAN_MASK_EN
  input  logic [N-1:0]  mask,
`endif
  output logic          en_out,
  output logic [AW-1:0] addr,
  output logic [N-1:0]  y,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(((DWELL > GAP) ? DWELL : GAP) + 1);

  scan_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d, done_q, done_d;

  // Candidate next address after the current one, and the first address of a scan.
  logic          nxt_ok, first_ok;
  logic [AW-1:0] nxt_addr, first_addr;

`ifdef SCAN_MASK_EN
  always_comb begin
    nxt_ok     = 1'b0;
    nxt_addr   = '0;
    first_ok   = 1'b0;
    first_addr = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (!mask[i] && i > int'(addr_q)) begin
        nxt_ok   = 1'b1;
        nxt_addr = AW'(i);
      end
      if (!mask[i]) begin
        first_ok   = 1'b1;
        first_addr = AW'(i);
      end
    end
  end
`else
  always_comb begin
    nxt_ok     = (addr_q != AW'(N-1));
    nxt_addr   = addr_q + AW'(1);
    first_ok   = 1'b1;
    first_addr = '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    en_d    = en_q;
    cnt_d   = cnt_q + CW'(1);
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        en_d   = 1'b0;
        addr_d = '0;
        if (start && !stop) begin
          if (first_ok) begin
            state_d = ACTIVE;
            addr_d  = first_addr;
            en_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (int'(cnt_q) == DWELL-1) begin
          cnt_d = '0;
          if (nxt_ok || (loop && first_ok)) begin
            if (GAP > 0) begin
              state_d = BLANK;
              en_d    = 1'b0;
              tgt_d   = nxt_ok ? nxt_addr : first_addr;
            end else begin
              addr_d = nxt_ok ? nxt_addr : first_addr;
            end
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
            addr_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      BLANK: begin
        // Target was latched at the advance decision; mask is not re-sampled here.
        if (int'(cnt_q) >= GAP-1) begin
          cnt_d   = '0;
          state_d = ACTIVE;
          addr_d  = tgt_q;
          en_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
      en_d    = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign en_out = en_q;
  assign addr   = addr_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

  dec_n_en #(.N(N), .AW(AW)) u_dec (
    .en   (en_q),
    .addr (addr_q),
    .y    (y)
  );

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl across several parameter sets.
module tb_dec_scan_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic [3:0] addr;
    logic [7:0] y;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_v, stop_v, loop_v;
  int         n_tests, n_fail;
  obs_t       exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d0: N=2 DWELL=4 GAP=1
  logic en0, busy0, done0;
  logic [0:0] addr0;
  logic [1:0] y0;
  dec_scan_ctrl #(.N(2), .DWELL(4), .GAP(1)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .loop(loop_v[0]),
`ifdef SCAN_MASK_EN
    .mask(2'b00),
`endif
    .en_out(en0), .addr(addr0), .y(y0), .busy(busy0), .done(done0));

  // d1: N=3 DWELL=2 GAP=0
  logic en1, busy1, done1;
  logic [1:0] addr1;
  logic [2:0] y1;
  dec_scan_ctrl #(.N(3), .DWELL(2), .GAP(0)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .loop(loop_v[1]),
`ifdef SCAN_MASK_EN
    .mask(3'b000),
`endif
    .en_out(en1), .addr(addr1), .y(y1), .busy(busy1), .done(done1));

  // d2: N=4 DWELL=3 GAP=1
  logic en2, busy2, done2;
  logic [1:0] addr2;
  logic [3:0] y2;
  dec_scan_ctrl #(.N(4), .DWELL(3), .GAP(1)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]), .loop(loop_v[2]),
`ifdef SCAN_MASK_EN
    .mask(4'b0000),
`endif
    .en_out(en2), .addr(addr2), .y(y2), .busy(busy2), .done(done2));

`ifdef SCAN_MASK_EN
  // d3: N=4 DWELL=2 GAP=1 with mask
  logic en3, busy3, done3;
  logic [1:0] addr3;
  logic [3:0] y3, mask3;
  dec_scan_ctrl #(.N(4), .DWELL(2), .GAP(1)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .stop(stop_v[3]), .loop(loop_v[3]),
    .mask(mask3),
    .en_out(en3), .addr(addr3), .y(y3), .busy(busy3), .done(done3));
`endif

  function automatic obs_t get_obs(input int d);
    obs_t o = '0;
    case (d)
      0: begin o.busy = busy0; o.done = done0; o.en = en0; o.addr = 4'(addr0); o.y = 8'(y0); end
      1: begin o.busy = busy1; o.done = done1; o.en = en1; o.addr = 4'(addr1); o.y = 8'(y1); end
      2: begin o.busy = busy2; o.done = done2; o.en = en2; o.addr = 4'(addr2); o.y = 8'(y2); end
`ifdef SCAN_MASK_EN
      3: begin o.busy = busy3; o.done = done3; o.en = en3; o.addr = 4'(addr3); o.y = 8'(y3); end
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  // Expected outputs t cycles after a single-shot start is accepted.
  function automatic obs_t exp_single(input int n, input int dw, input int gp, input int t);
    obs_t o = '0;
    int   p = dw + gp;
    int   b = n*dw + (n-1)*gp;
    if (t >= 0 && t < b) begin
      o.busy = 1'b1;
      o.addr = 4'(t / p);
      o.en   = (t % p) < dw;
      if (o.en) o.y = 8'(1) << (t / p);
    end else if (t == b) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // N=3, DWELL=2, GAP=0 looping scan.
  function automatic obs_t exp_loop3(input int t);
    obs_t o = '0;
    o.busy = 1'b1;
    o.en   = 1'b1;
    o.addr = 4'((t / 2) % 3);
    o.y    = 8'(1) << ((t / 2) % 3);
    return o;
  endfunction

  function automatic obs_t mk(input logic b, input logic d, input logic e, input int a, input int yv);
    obs_t o;
    o.busy = b; o.done = d; o.en = e; o.addr = 4'(a); o.y = 8'(yv);
    return o;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    obs_t o;
    rst_n = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      o = get_obs(d);
      n_tests++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset d%0d got=%h exp=%h", d, o, obs_t'('0));
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid;
    obs_t o, e;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e = exp_single(2, 4, 1, c-1);
      o = get_obs(0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, o, e);
      end
      if (c < 3) tick();
    end
    // Asynchronous: outputs must drop before the next clock edge.
    rst_n = 1'b0;
    #1;
    o = get_obs(0);
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h exp=%h", o, obs_t'('0));
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      o = get_obs(0);
      n_tests++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_post c=%0d got=%h exp=%h", c, o, obs_t'('0));
      end
    end
  endtask

  task automatic test_single_shot;
    obs_t o, e;
    int   b = 2*4 + 1*1;
    exp_q.delete();
    for (int t = 0; t <= b+1; t++) exp_q.push_back(exp_single(2, 4, 1, t));
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 1; c <= b+2; c++) begin
      e = exp_q.pop_front();
      o = get_obs(0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single c=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    obs_t o, e;
    int   b = 4*3 + 3*1;
    exp_q.delete();
    for (int t = 0; t <= b; t++)   exp_q.push_back(exp_single(4, 3, 1, t));
    for (int t = 0; t <= b+1; t++) exp_q.push_back(exp_single(4, 3, 1, t));
    start_v[2] = 1'b1;
    tick();
    for (int c = 1; c <= 2*b+3; c++) begin
      e = exp_q.pop_front();
      o = get_obs(2);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, o, e);
      end
      // Restart on the done cycle.
      start_v[2] = (c == b+1);
      tick();
    end
    start_v[2] = 1'b0;
  endtask

  task automatic test_loop_gap0;
    obs_t o, e;
    exp_q.delete();
    for (int t = 0; t < 18; t++) exp_q.push_back(exp_loop3(t));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0, 0));
    exp_q.push_back('0);
    loop_v[1]  = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      e = exp_q.pop_front();
      o = get_obs(1);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loop_gap0 c=%0d got=%h exp=%h", c, o, e);
      end
      if (c == 15) loop_v[1] = 1'b0;
      tick();
    end
  endtask

  task automatic test_stop;
    obs_t o, e;
    exp_q.delete();
    for (int t = 0; t < 15; t++) exp_q.push_back(exp_single(4, 3, 1, t));
    repeat (3) exp_q.push_back('0);
    start_v[2] = 1'b1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      e = exp_q.pop_front();
      o = get_obs(2);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stop c=%0d got=%h exp=%h", c, o, e);
      end
      // Start is held through the scan; stop lands on the last dwell of addr 3.
      if (c == 15) begin stop_v[2] = 1'b1; start_v[2] = 1'b0; end
      if (c == 16) stop_v[2] = 1'b0;
      if (c == 17) begin stop_v[2] = 1'b1; start_v[2] = 1'b1; end
      tick();
    end
    stop_v[2]  = 1'b0;
    start_v[2] = 1'b0;
  endtask

  task automatic test_nonpow2;
    obs_t o, e;
    exp_q.delete();
    for (int t = 0; t < 120; t++) exp_q.push_back(exp_loop3(t));
    loop_v[1]  = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      e = exp_q.pop_front();
      o = get_obs(1);
      n_tests++;
      if (o.addr >= 4'd3 || (o.y != 8'd0 && !$onehot(o.y)) || o !== e) begin
        n_fail++;
        $display("FAIL nonpow2 c=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
    stop_v[1] = 1'b1;
    loop_v[1] = 1'b0;
    tick();
    stop_v[1] = 1'b0;
    o = get_obs(1);
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL nonpow2_stop got=%h exp=%h", o, obs_t'('0));
    end
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask;
    obs_t o, e;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1, 2));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1, 2));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1, 0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 3, 8));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 3, 8));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0, 0));
    exp_q.push_back('0);
    mask3      = 4'b0101;
    start_v[3] = 1'b1;
    tick();
    start_v[3] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      e = exp_q.pop_front();
      o = get_obs(3);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mask0101 c=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0, 0));
    exp_q.push_back('0);
    mask3      = 4'b1111;
    start_v[3] = 1'b1;
    tick();
    start_v[3] = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      e = exp_q.pop_front();
      o = get_obs(3);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mask1111 c=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start_v = '0;
    stop_v  = '0;
    loop_v  = '0;
`ifdef SCAN_MASK_EN
    mask3   = '0;
`endif
    test_reset();
    test_reset_mid();
    test_single_shot();
    test_back_to_back();
    test_loop_gap0();
    test_stop();
    test_nonpow2();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
